mstage_lsu: RTL and testbench

Memory-access stage between the execute-stage pipeline register and write-back. Accepts one instruction bundle per valid/ready handshake. For loads and stores it runs one AXI4-Lite transaction; it then aligns and extends load data and holds the registered result for the write-back stage. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mstage_lsu_pkg.sv | 26 ++
 rtl/mstage_lsu_load_ext.sv | 26 ++
 rtl/mstage_lsu.sv | 169 ++++++++++++++++
 tb/tb_mstage_lsu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mstage_lsu_pkg.sv
// Shared definitions for the memory stage: load-type encodings, reset PC,
// AXI response codes and the write-back pass-through bundle.
package mstage_lsu_pkg;

  localparam logic [2:0]  MRT_LB   = 3'd0;
  localparam logic [2:0]  MRT_LH   = 3'd1;
  localparam logic [2:0]  MRT_LW   = 3'd2;
  localparam logic [2:0]  MRT_LBU  = 3'd4;
  localparam logic [2:0]  MRT_LHU  = 3'd5;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [1:0]  AXI_OKAY = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alures;
    logic [4:0]  rd;
    logic [2:0]  rdregsrc;
  } wb_pass_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] lo);
    return ((mask == 4'h3) && lo[0]) || ((mask == 4'hF) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mstage_lsu_load_ext.sv
// Combinational load alignment: shift the bus word down to the addressed
// byte lane, then sign/zero extend according to the load type.
module lsu_load_ext
  import mstage_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mrtype_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = sh;
    case (mrtype_i)
      MRT_LB:  data_o = {{24{sh[7]}},  sh[7:0]};
      MRT_LH:  data_o = {{16{sh[15]}}, sh[15:0]};
      MRT_LBU: data_o = {24'h0, sh[7:0]};
      MRT_LHU: data_o = {16'h0, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/mstage_lsu.sv
// Memory-access stage: one AXI4-Lite transaction per load/store, registered
// result for write-back. Define LSU_ALIGN_CHECK_EN to fault misaligned ops.
module mstage_lsu
  import mstage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              mvalidX,
  input  logic              mwenX,
  input  logic [7:0]        mwmaskX,
  input  logic [2:0]        mrtypeX,
  input  logic [31:0]       aluresX,
  input  logic [31:0]       src2X,
  input  logic [2:0]        rdregsrcX,
  input  logic [4:0]        rdX,
  input  logic [31:0]       pcX,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       aluresM,
  output logic [31:0]       pcM,
  output logic [2:0]        rdregsrcM,
  output logic [4:0]        rdM,
  output logic [31:0]       mrdataM,
  output logic              merrM,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE
  } state_e;

  state_e state_q, state_d;

  wb_pass_t          pass_q;
  logic [2:0]        mrtype_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       mrdata_q;
  logic              merr_q;
  logic              aw_done_q, w_done_q;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic              mis;
  logic [7:0]        strb_sh;
  logic [31:0]       ld_data;
  logic [7:0]        unused_bits;

`ifdef LSU_ALIGN_CHECK_EN
  assign mis = mvalidX && misaligned(mwmaskX[3:0], aluresX[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Lanes shifted past bit 3 by a misaligned address fall off the bus.
  assign strb_sh     = {4'h0, mwmaskX[3:0]} << aluresX[1:0];
  assign unused_bits = {strb_sh[7:4], mwmaskX[7:4]};

  lsu_load_ext u_ext (
    .rdata_i  (rdata[31:0]),
    .addr_lo_i(addr_lo_q),
    .mrtype_i (mrtype_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (s_valid) begin
                   if (!mvalidX || mis) state_d = S_DONE;
                   else if (mwenX)      state_d = S_WR;
                   else                 state_d = S_RD_ADDR;
                 end
      S_RD_ADDR: if (arready) state_d = S_RD_DATA;
      S_RD_DATA: if (rvalid)  state_d = S_DONE;
      S_WR:      if ((aw_done_q || awready) && (w_done_q || wready)) state_d = S_WR_RESP;
      S_WR_RESP: if (bvalid)  state_d = S_DONE;
      S_DONE:    if (m_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q    <= '{pc: RESET_PC, alures: '0, rd: '0, rdregsrc: '0};
      mrtype_q  <= '0;
      addr_lo_q <= '0;
      mrdata_q  <= '0;
      merr_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (s_valid) begin
          pass_q    <= '{pc: pcX, alures: aluresX, rd: rdX, rdregsrc: rdregsrcX};
          mrtype_q  <= mrtypeX;
          addr_lo_q <= aluresX[1:0];
          mrdata_q  <= '0;
          merr_q    <= mis;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          araddr_q  <= {aluresX[ADDR_W-1:2], 2'b00};
          awaddr_q  <= {aluresX[ADDR_W-1:2], 2'b00};
          wdata_q   <= DATA_W'(src2X << {aluresX[1:0], 3'b000});
          wstrb_q   <= strb_sh[3:0];
        end
        S_WR: begin
          if (awready) aw_done_q <= 1'b1;
          if (wready)  w_done_q  <= 1'b1;
        end
        S_RD_DATA: if (rvalid) begin
          mrdata_q <= ld_data;
          merr_q   <= (rresp != AXI_OKAY);
        end
        S_WR_RESP: if (bvalid) merr_q <= (bresp != AXI_OKAY);
        default: ;
      endcase
    end
  end

  assign s_ready   = (state_q == S_IDLE);
  assign m_valid   = (state_q == S_DONE);
  assign arvalid   = (state_q == S_RD_ADDR);
  assign rready    = (state_q == S_RD_DATA);
  assign awvalid   = (state_q == S_WR) && !aw_done_q;
  assign wvalid    = (state_q == S_WR) && !w_done_q;
  assign bready    = (state_q == S_WR_RESP);
  assign araddr    = araddr_q;
  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign aluresM   = pass_q.alures;
  assign pcM       = pass_q.pc;
  assign rdM       = pass_q.rd;
  assign rdregsrcM = pass_q.rdregsrc;
  assign mrdataM   = mrdata_q;
  assign merrM     = merr_q;

endmodule

// File: tb/tb_mstage_lsu.sv
// Scoreboard bench for mstage_lsu with a small AXI4-Lite slave model.
module tb_mstage_lsu;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid = 0, s_ready, mvalidX = 0, mwenX = 0;
  logic [7:0]  mwmaskX = 0;
  logic [2:0]  mrtypeX = 0, rdregsrcX = 0, rdregsrcM;
  logic [31:0] aluresX = 0, src2X = 0, pcX = 0;
  logic [4:0]  rdX = 0, rdM;
  logic        m_valid, m_ready = 1, merrM;
  logic [31:0] aluresM, pcM, mrdataM;
  logic [31:0] araddr, awaddr, wdata, rdata = 0;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp = 0, bresp = 0;

  mstage_lsu dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .mvalidX(mvalidX), .mwenX(mwenX), .mwmaskX(mwmaskX), .mrtypeX(mrtypeX),
    .aluresX(aluresX), .src2X(src2X), .rdregsrcX(rdregsrcX), .rdX(rdX), .pcX(pcX),
    .m_valid(m_valid), .m_ready(m_ready), .aluresM(aluresM), .pcM(pcM),
    .rdregsrcM(rdregsrcM), .rdM(rdM), .mrdataM(mrdataM), .merrM(merrM),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, hs_cyc = 0;
  int mv_rise = 0, br_rise = 0, ax_cnt = 0;
  logic mv_prev = 0, br_prev = 0;

  // slave behaviour knobs and expected bus fields
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [31:0] s_rdata = 0, exp_araddr = 0, exp_awaddr = 0, exp_wdata = 0;
  logic [3:0]  exp_wstrb = 0;
  logic [1:0]  s_rresp = 0, s_bresp = 0;

  typedef struct {
    logic [31:0] alures, pc, mrdata;
    logic [4:0]  rd;
    logic [2:0]  rdregsrc;
    logic        merr;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the head entry on every m_valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        if (!mv_prev && sbq[0].lat >= 0) chk("latency", cyc - sbq[0].acc, sbq[0].lat);
        chk("aluresM", aluresM, sbq[0].alures);
        chk("pcM", pcM, sbq[0].pc);
        chk("rdM", 32'(rdM), 32'(sbq[0].rd));
        chk("rdregsrcM", 32'(rdregsrcM), 32'(sbq[0].rdregsrc));
        chk("mrdataM", mrdataM, sbq[0].mrdata);
        chk("merrM", 32'(merrM), 32'(sbq[0].merr));
        chk("s_ready_in_done", 32'(s_ready), 0);
        if (m_ready) begin
          void'(sbq.pop_front());
          hs_cyc <= cyc;
        end
      end
    end
    if (m_valid && !mv_prev) mv_rise <= mv_rise + 1;
    if (bready && !br_prev)  br_rise <= br_rise + 1;
    if (arvalid || awvalid || wvalid) ax_cnt <= ax_cnt + 1;
    mv_prev <= m_valid;
    br_prev <= bready;
  end

  // AXI slave: each channel accepts after its configured number of wait cycles.
  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      arready = 0;
      if (!arvalid) n = 0;
      else begin
        chk("araddr", araddr, exp_araddr);
        if (n >= ar_delay) begin arready = 1; n = 0; end
        else n++;
      end
    end
  end

  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      awready = 0;
      if (!awvalid) n = 0;
      else begin
        chk("awaddr", awaddr, exp_awaddr);
        if (n >= aw_delay) begin awready = 1; n = 0; end
        else n++;
      end
    end
  end

  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      wready = 0;
      if (!wvalid) n = 0;
      else begin
        chk("wdata", wdata, exp_wdata);
        chk("wstrb", 32'(wstrb), 32'(exp_wstrb));
        if (n >= w_delay) begin wready = 1; n = 0; end
        else n++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    rvalid = rready; rdata = s_rdata; rresp = s_rresp;
    bvalid = bready; bresp = s_bresp;
  end

  task automatic issue(input logic mv, input logic we, input logic [7:0] mask,
                       input logic [2:0] mrt, input logic [31:0] addr, input logic [31:0] s2,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] rsel,
                       input logic [31:0] e_rdata, input logic e_merr, input int lat,
                       input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk);
    mvalidX = mv; mwenX = we; mwmaskX = mask; mrtypeX = mrt; aluresX = addr;
    src2X = s2; pcX = pc; rdX = rd; rdregsrcX = rsel; s_valid = 1;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(s_ready), 1);
    acc_cyc = cyc;
    e = '{alures: addr, pc: pc, mrdata: e_rdata, rd: rd, rdregsrc: rsel,
          merr: e_merr, lat: lat, acc: cyc};
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1 s_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", 32'(sbq.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int ax0, b0, m0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_axi_valids", {27'h0, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_pcM", pcM, 32'h8000_0000);
    chk("rst_aluresM", aluresM, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_wstrb", 32'(wstrb), 0);
    chk("rst_merrM", 32'(merrM), 0);
    rst = 0;

    // ALU pass-through
    ax0 = ax_cnt;
    issue(0, 0, 8'h00, 3'd0, 32'h0000_1234, 0, 32'h8000_0010, 5, 3'd1, 0, 0, 1, 1);
    drain();
    chk("alu_no_axi", ax_cnt - ax0, 0);

    // Loads, zero-wait slave
    s_rdata = 32'h80FF_FF7F; exp_araddr = 32'h8000_1000;
    issue(1, 0, 8'h01, 3'd0, 32'h8000_1003, 0, 32'h8000_0020, 7, 3'd2, 32'hFFFF_FF80, 0, 3, 1);
    issue(1, 0, 8'h01, 3'd4, 32'h8000_1003, 0, 32'h8000_0024, 8, 3'd2, 32'h0000_0080, 0, 3, 1);
    drain();
    s_rdata = 32'h8001_0000; exp_araddr = 32'h8000_4000;
    issue(1, 0, 8'h03, 3'd1, 32'h8000_4002, 0, 32'h8000_0028, 9, 3'd2, 32'hFFFF_8001, 0, 3, 1);
    issue(1, 0, 8'h03, 3'd5, 32'h8000_4002, 0, 32'h8000_002C, 9, 3'd2, 32'h0000_8001, 0, 3, 1);
    drain();

    // SH with awready three cycles after wready
    aw_delay = 3; exp_awaddr = 32'h8000_2000; exp_wdata = 32'hBEEF_0000; exp_wstrb = 4'hC;
    b0 = br_rise; m0 = mv_rise;
    issue(1, 1, 8'h03, 3'd0, 32'h8000_2002, 32'h0000_BEEF, 32'h8000_0030, 0, 3'd0, 0, 0, -1, 1);
    drain();
    chk("sh_wr_resp_once", br_rise - b0, 1);
    chk("sh_m_valid_once", mv_rise - m0, 1);

    // SB with ignored upper mask bits, wready delayed
    aw_delay = 0; w_delay = 2; exp_awaddr = 32'h8000_5000; exp_wdata = 32'h0000_A500; exp_wstrb = 4'h2;
    issue(1, 1, 8'hF1, 3'd0, 32'h8000_5001, 32'h0000_00A5, 32'h8000_0034, 0, 3'd0, 0, 0, -1, 1);
    drain();

    // SW zero-wait with SLVERR
    w_delay = 0; s_bresp = 2'b10; exp_awaddr = 32'h8000_5004; exp_wdata = 32'hDEAD_BEEF; exp_wstrb = 4'hF;
    issue(1, 1, 8'h0F, 3'd0, 32'h8000_5004, 32'hDEAD_BEEF, 32'h8000_0038, 0, 3'd0, 0, 1, 3, 1);
    drain();
    s_bresp = 0;

    // LW with read error and arready delayed four cycles
    ar_delay = 4; s_rresp = 2'b10; s_rdata = 32'h1122_3344; exp_araddr = 32'h8000_3008;
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_3008, 0, 32'h8000_003C, 12, 3'd2, 32'h1122_3344, 1, -1, 1);
    drain();
    chk("idle_after_err", 32'(s_ready), 1);
    ar_delay = 0; s_rresp = 0;

    // m_ready low for five cycles; next bundle waits for the handshake
    m_ready = 0;
    issue(0, 0, 8'h00, 3'd0, 32'h0000_000A, 0, 32'h8000_0100, 10, 3'd1, 0, 0, 1, 1);
    fork
      issue(0, 0, 8'h00, 3'd0, 32'h0000_000B, 0, 32'h8000_0104, 11, 3'd1, 0, 0, 1, 1);
      begin repeat (5) @(posedge clk); #1 m_ready = 1; end
    join
    chk("accept_after_hs", acc_cyc - hs_cyc, 1);
    drain();

    // Misaligned accesses
    ax0 = ax_cnt;
`ifdef LSU_ALIGN_CHECK_EN
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_0002, 0, 32'h8000_0200, 3, 3'd2, 0, 1, 1, 1);
    issue(1, 1, 8'h0F, 3'd0, 32'h8000_6003, 32'h1122_3344, 32'h8000_0204, 0, 3'd0, 0, 1, 1, 1);
    drain();
    chk("misalign_no_axi", ax_cnt - ax0, 0);
`else
    s_rdata = 32'hAABB_CCDD; exp_araddr = 32'h8000_0000;
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_0002, 0, 32'h8000_0200, 3, 3'd2, 32'h0000_AABB, 0, 3, 1);
    drain();
    exp_awaddr = 32'h8000_6000; exp_wdata = 32'h4400_0000; exp_wstrb = 4'h8;
    issue(1, 1, 8'h0F, 3'd0, 32'h8000_6003, 32'h1122_3344, 32'h8000_0204, 0, 3'd0, 0, 0, 3, 1);
    drain();
    chk("misalign_issued", 32'(ax_cnt != ax0), 1);
`endif

    // Reset in the middle of a stalled read
    ar_delay = 50; exp_araddr = 32'h8000_7000;
    issue(1, 0, 8'h0F, 3'd2, 32'h8000_7000, 0, 32'h8000_0300, 4, 3'd2, 0, 0, -1, 0);
    repeat (3) @(negedge clk);
    chk("arvalid_before_rst", 32'(arvalid), 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_arvalid", 32'(arvalid), 0);
    chk("rst_mid_m_valid", 32'(m_valid), 0);
    chk("rst_mid_s_ready", 32'(s_ready), 1);
    chk("rst_mid_pcM", pcM, 32'h8000_0000);
    rst = 0; ar_delay = 0;
    issue(0, 0, 8'h00, 3'd0, 32'h0000_0777, 0, 32'h8000_0400, 21, 3'd3, 0, 0, 1, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
